// File: rtl/pc_sequencer_rv32i_pkg.sv
// Shared types and constants for the RV32I fetch sequencer.
package pc_sequencer_rv32i_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/pc_sequencer_rv32i.sv
// Architectural PC owner and instruction-fetch sequencer: one outstanding
// imem request, a single held instruction for decode, branch redirect/squash.
module pc_sequencer_rv32i
  import pc_sequencer_rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        trap_misalign,
  output logic        fetch_err
);

  state_t           state_reg;
  logic [31:0]      pc_reg;
  logic [CNT_W-1:0] wdog_reg;
  logic [CNT_W-1:0] wdog_next;
  logic             br_redirect;
  logic             br_misalign;
  logic             wdog_expire;

  always_comb begin
    br_redirect = br_valid & br_taken & (br_target[1:0] == 2'b00);
    br_misalign = br_valid & br_taken & (br_target[1:0] != 2'b00);
    wdog_next   = wdog_reg + 1'b1;
    // Only consulted in FETCH/DRAIN; a zero TIMEOUT disables the watchdog.
    wdog_expire = (TIMEOUT != 0) && !imem_ready && (wdog_next == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= RESET_PC;
      wdog_reg      <= '0;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      inst_valid    <= 1'b0;
      inst          <= NOP_INST;
      inst_pc       <= RESET_PC;
      trap_misalign <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      trap_misalign <= 1'b0;
      wdog_reg      <= '0;
      case (state_reg)
        ST_IDLE: begin
          trap_misalign <= br_misalign;
          state_reg     <= ST_FETCH;
          imem_req      <= 1'b1;
          if (br_redirect) begin
            pc_reg    <= br_target;
            imem_addr <= br_target;
          end else begin
            imem_addr <= pc_reg;
          end
        end
        ST_FETCH: begin
          trap_misalign <= br_misalign;
          if (wdog_expire) begin
            fetch_err  <= 1'b1;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            state_reg  <= ST_HALT;
          end else if (imem_ready) begin
            if (br_redirect) begin
              // Wrong-path response dropped; refetch immediately at the target.
              pc_reg    <= br_target;
              imem_addr <= br_target;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= pc_reg;
              inst_valid <= 1'b1;
              pc_reg     <= pc_reg + PC_INC;
              imem_req   <= 1'b0;
              state_reg  <= ST_HOLD;
            end
          end else begin
            wdog_reg <= wdog_next;
            if (br_redirect) begin
              // The request is already on the bus; let it complete, then drop it.
              pc_reg    <= br_target;
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_HOLD: begin
          trap_misalign <= br_misalign;
          if (br_redirect) begin
            inst_valid <= 1'b0;
            pc_reg     <= br_target;
            imem_req   <= 1'b1;
            imem_addr  <= br_target;
            state_reg  <= ST_FETCH;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            imem_addr  <= pc_reg;
            state_reg  <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          trap_misalign <= br_misalign;
          if (wdog_expire) begin
            fetch_err  <= 1'b1;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            state_reg  <= ST_HALT;
          end else if (imem_ready) begin
            state_reg <= ST_FETCH;
            if (br_redirect) begin
              pc_reg    <= br_target;
              imem_addr <= br_target;
            end else begin
              imem_addr <= pc_reg;
            end
          end else begin
            wdog_reg <= wdog_next;
            if (br_redirect) begin
              pc_reg <= br_target;
            end
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: begin
          state_reg <= ST_IDLE;
          imem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer_rv32i.sv
// Directed bench for pc_sequencer_rv32i: sequential fetch, wait states,
// redirect in HOLD and FETCH/DRAIN, misaligned target, watchdog halt.
module tb_pc_sequencer_rv32i;

  localparam logic [31:0] KEY = 32'hDEAD_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_misalign;
  logic        fetch_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the requested address.
  assign imem_rdata = imem_addr ^ KEY;

  pc_sequencer_rv32i #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .trap_misalign(trap_misalign),
    .fetch_err    (fetch_err)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic branch(input logic v, input logic t, input logic [31:0] tgt);
    br_valid  = v;
    br_taken  = t;
    br_target = tgt;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; inst_ready = 1'b0;
    branch(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    step(); step();
    check_vec("rst_req",   {31'b0, imem_req},   32'd0);
    check_vec("rst_valid", {31'b0, inst_valid}, 32'd0);
    check_vec("rst_inst",  inst,                NOP);
    check_vec("rst_ipc",   inst_pc,             32'h0);
    check_vec("rst_addr",  imem_addr,           32'h0);
    check_vec("rst_err",   {31'b0, fetch_err},  32'd0);

    // Zero-wait sequential fetch
    rst = 1'b0;
    step();
    check_vec("f0_req",  {31'b0, imem_req}, 32'd1);
    check_vec("f0_addr", imem_addr,         32'h0);
    imem_ready = 1'b1; inst_ready = 1'b1;
    step();
    check_vec("h0_valid", {31'b0, inst_valid}, 32'd1);
    check_vec("h0_inst",  inst,                32'h0 ^ KEY);
    check_vec("h0_ipc",   inst_pc,             32'h0);
    check_vec("h0_req",   {31'b0, imem_req},   32'd0);
    step();
    check_vec("f1_addr",  imem_addr,           32'h4);
    check_vec("f1_valid", {31'b0, inst_valid}, 32'd0);

    // Three wait states at 0x4
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec($sformatf("wait%0d_addr", i), imem_addr, 32'h4);
      check_vec($sformatf("wait%0d_req", i),  {31'b0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1; inst_ready = 1'b0;
    step();
    check_vec("h1_inst", inst,    32'h4 ^ KEY);
    check_vec("h1_ipc",  inst_pc, 32'h4);
    step();
    check_vec("h1_stall_valid", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    step();
    check_vec("f2_addr", imem_addr, 32'h8);
    step();
    check_vec("h2_ipc", inst_pc, 32'h8);

    // Redirect while holding 0x8, decode accepting the same cycle
    branch(1'b1, 1'b1, 32'h100);
    step();
    branch(1'b0, 1'b0, 32'h0);
    check_vec("sq_valid", {31'b0, inst_valid}, 32'd0);
    check_vec("sq_addr",  imem_addr,           32'h100);
    step();
    check_vec("h3_ipc", inst_pc, 32'h100);
    step();
    check_vec("f4_addr", imem_addr, 32'h104);

    // Redirect during an unanswered fetch: drain the old request
    imem_ready = 1'b0;
    branch(1'b1, 1'b1, 32'h200);
    step();
    branch(1'b0, 1'b0, 32'h0);
    check_vec("dr0_addr", imem_addr,         32'h104);
    check_vec("dr0_req",  {31'b0, imem_req}, 32'd1);
    step();
    check_vec("dr1_addr", imem_addr, 32'h104);
    imem_ready = 1'b1;
    step();
    check_vec("dr_discard_valid", {31'b0, inst_valid}, 32'd0);
    check_vec("dr_discard_ipc",   inst_pc,             32'h100);
    check_vec("dr_next_addr",     imem_addr,           32'h200);
    step();
    check_vec("h5_ipc", inst_pc, 32'h200);

    // Misaligned taken target: trap pulse, sequential flow continues
    branch(1'b1, 1'b1, 32'h102);
    step();
    branch(1'b0, 1'b0, 32'h0);
    check_vec("mis_trap", {31'b0, trap_misalign}, 32'd1);
    check_vec("mis_addr", imem_addr,              32'h204);
    step();
    check_vec("mis_trap_clr", {31'b0, trap_misalign}, 32'd0);
    check_vec("mis_ipc",      inst_pc,                32'h204);

    // Not-taken branch has no effect
    branch(1'b1, 1'b0, 32'h300);
    step();
    branch(1'b0, 1'b0, 32'h0);
    check_vec("nt_addr", imem_addr, 32'h208);

    // Watchdog: 4 cycles without ready halts the sequencer
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec($sformatf("wd%0d_err", i), {31'b0, fetch_err}, 32'd0);
    end
    step();
    check_vec("wd_err", {31'b0, fetch_err}, 32'd1);
    check_vec("wd_req", {31'b0, imem_req},  32'd0);
    imem_ready = 1'b1; inst_ready = 1'b1;
    branch(1'b1, 1'b1, 32'h400);
    step(); step();
    branch(1'b0, 1'b0, 32'h0);
    check_vec("halt_err",   {31'b0, fetch_err},  32'd1);
    check_vec("halt_req",   {31'b0, imem_req},   32'd0);
    check_vec("halt_valid", {31'b0, inst_valid}, 32'd0);

    // Reset recovers; a stray ready in IDLE is ignored
    rst = 1'b1;
    step();
    check_vec("rr_err",  {31'b0, fetch_err}, 32'd0);
    check_vec("rr_addr", imem_addr,          32'h0);
    rst = 1'b0;
    step();
    check_vec("rr_req",   {31'b0, imem_req},   32'd1);
    check_vec("rr_fa",    imem_addr,           32'h0);
    check_vec("rr_valid", {31'b0, inst_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
